mvprod_sched: RTL and testbench

MVPROD_SCHED -- requirements
Module: mvprod_sched

---
 rtl/mvprod_sched_if.sv | 46 ++++
 rtl/mvprod_sched.sv | 172 +++++++++++++++++
 tb/tb_mvprod_sched.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mvprod_sched_if.sv
// mvprod_sched_if -- bundles the three streams around the matrix-vector scheduler:
// the upstream int8 element stream, the engine request/chunk channel and the
// downstream result stream, plus the sticky protocol error flag.
// The slave modport is the scheduler's view; the master modport is the view of
// whatever surrounds it (upstream source, engine and result sink together).
interface mvprod_sched_if #(
    parameter int WORKING_REGS = 3
);
    logic                        s_valid;
    logic signed [7:0]           s_data;
    logic                        s_ready;

    logic                        mv_start;
    logic [WORKING_REGS*8-1:0]   mv_chunk;
    logic                        mv_req_chunk_in;
    logic                        mv_req_ptr_rst;
    logic                        mv_req_chunk_out;
    logic signed [7:0]           mv_result;

    logic                        m_valid;
    logic signed [7:0]           m_data;
    logic                        m_last;
    logic                        m_ready;

    logic                        err_overflow;

    modport slave (
        input  s_valid, s_data,
        input  mv_req_chunk_in, mv_req_ptr_rst, mv_req_chunk_out, mv_result,
        input  m_ready,
        output s_ready,
        output mv_start, mv_chunk,
        output m_valid, m_data, m_last,
        output err_overflow
    );

    modport master (
        output s_valid, s_data,
        output mv_req_chunk_in, mv_req_ptr_rst, mv_req_chunk_out, mv_result,
        output m_ready,
        input  s_ready,
        input  mv_start, mv_chunk,
        input  m_valid, m_data, m_last,
        input  err_overflow
    );
endinterface

// File: rtl/mvprod_sched.sv
// mvprod_sched -- buffers one int8 input vector, starts the matrix-vector engine,
// serves it WORKING_REGS-element chunks on request, captures its results and
// streams them out with a last marker.
// Optional feature: define MVPROD_SCHED_RELU_EN to clamp negative captured
// results to zero; by default results are stored unmodified.
// Clock clk_in (rising edge); reset rst_in is synchronous and active-low.
module mvprod_sched #(
    parameter int IN_VEC_LEN   = 6,
    parameter int OUT_VEC_LEN  = 4,
    parameter int WORKING_REGS = 3
) (
    input  logic           clk_in,
    input  logic           rst_in,
    mvprod_sched_if.slave  bus
);

    localparam int PTR_W = (IN_VEC_LEN  > 1) ? $clog2(IN_VEC_LEN)  : 1;
    localparam int RES_W = (OUT_VEC_LEN > 1) ? $clog2(OUT_VEC_LEN) : 1;

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_START   = 2'd1;
    localparam logic [1:0] ST_COMPUTE = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

    logic [1:0]                r_state;
    logic [1:0]                w_stateNext;
    logic [PTR_W-1:0]          r_wrIdx;
    logic [PTR_W-1:0]          r_rdPtr;
    logic [PTR_W-1:0]          w_base;
    logic [PTR_W-1:0]          w_ptrNext;
    logic [RES_W-1:0]          r_resCnt;
    logic [RES_W-1:0]          r_rdOut;
    logic signed [7:0]         r_inBuf  [IN_VEC_LEN];
    logic signed [7:0]         r_outBuf [OUT_VEC_LEN];
    logic [WORKING_REGS*8-1:0] r_chunk;
    logic [WORKING_REGS*8-1:0] w_chunkNext;
    logic                      r_sReady;
    logic                      r_err;
    logic signed [7:0]         w_capVal;

    logic w_compute;
    logic w_drain;
    logic w_inFire;
    logic w_outFire;
    logic w_drainFire;
    logic w_lastIn;
    logic w_lastRes;
    logic w_lastOut;

    assign w_compute   = (r_state == ST_COMPUTE);
    assign w_drain     = (r_state == ST_DRAIN);
    assign w_inFire    = (r_state == ST_LOAD) && bus.s_valid && r_sReady;
    assign w_outFire   = w_compute && bus.mv_req_chunk_out;
    assign w_drainFire = w_drain && bus.m_ready;
    assign w_lastIn    = (r_wrIdx  == PTR_W'(IN_VEC_LEN - 1));
    assign w_lastRes   = (r_resCnt == RES_W'(OUT_VEC_LEN - 1));
    assign w_lastOut   = (r_rdOut  == RES_W'(OUT_VEC_LEN - 1));

    // A pointer reset in the same cycle as a chunk request makes the chunk come from index 0
    always_comb begin
        w_base      = bus.mv_req_ptr_rst ? '0 : r_rdPtr;
        w_chunkNext = '0;
        for (int k = 0; k < WORKING_REGS; k++) begin
            w_chunkNext[k*8 +: 8] = r_inBuf[PTR_W'(int'(w_base) + k)];
        end
        if (int'(w_base) + WORKING_REGS >= IN_VEC_LEN) begin
            w_ptrNext = '0;
        end else begin
            w_ptrNext = PTR_W'(int'(w_base) + WORKING_REGS);
        end
    end

    // Captured value, optionally rectified before it reaches the output buffer
    always_comb begin
`ifdef MVPROD_SCHED_RELU_EN
        w_capVal = bus.mv_result[7] ? 8'sd0 : bus.mv_result;
`else
        w_capVal = bus.mv_result;
`endif
    end

    // Next-state decode: each phase ends on the handshake that consumes its last element
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_LOAD:    if (w_inFire && w_lastIn)       w_stateNext = ST_START;
            ST_START:                                   w_stateNext = ST_COMPUTE;
            ST_COMPUTE: if (w_outFire && w_lastRes)     w_stateNext = ST_DRAIN;
            ST_DRAIN:   if (w_drainFire && w_lastOut)   w_stateNext = ST_LOAD;
            default:                                    w_stateNext = ST_LOAD;
        endcase
    end

    // State register plus the registered s_ready, which stays low for the reset cycle
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state  <= ST_LOAD;
            r_sReady <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_sReady <= (w_stateNext == ST_LOAD);
        end
    end

    // Write index, chunk read pointer, result count and drain index
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_wrIdx  <= '0;
            r_rdPtr  <= '0;
            r_resCnt <= '0;
            r_rdOut  <= '0;
        end else begin
            if (w_inFire) begin
                r_wrIdx <= w_lastIn ? '0 : r_wrIdx + PTR_W'(1);
            end
            if (r_state == ST_START) begin
                r_rdPtr  <= '0;
                r_resCnt <= '0;
            end
            if (w_compute) begin
                if (bus.mv_req_chunk_in) begin
                    r_rdPtr <= w_ptrNext;
                end else if (bus.mv_req_ptr_rst) begin
                    r_rdPtr <= '0;
                end
            end
            if (w_outFire) begin
                r_resCnt <= w_lastRes ? '0 : r_resCnt + RES_W'(1);
            end
            if (w_drainFire) begin
                r_rdOut <= w_lastOut ? '0 : r_rdOut + RES_W'(1);
            end
        end
    end

    // Chunk register presented to the engine; holds until the next request
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_chunk <= '0;
        end else if (w_compute && bus.mv_req_chunk_in) begin
            r_chunk <= w_chunkNext;
        end
    end

    // Engine requests arriving outside COMPUTE are dropped and latch the error flag
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_err <= 1'b0;
        end else if (!w_compute && (bus.mv_req_chunk_in || bus.mv_req_chunk_out)) begin
            r_err <= 1'b1;
        end
    end

    // Data buffers carry no reset; a reset run never reaches DRAIN so stale data is never shown
    always_ff @(posedge clk_in) begin
        if (rst_in && w_inFire) begin
            r_inBuf[r_wrIdx] <= bus.s_data;
        end
        if (rst_in && w_outFire) begin
            r_outBuf[r_resCnt] <= w_capVal;
        end
    end

    assign bus.s_ready      = r_sReady;
    assign bus.mv_start     = (r_state == ST_START);
    assign bus.mv_chunk     = r_chunk;
    assign bus.m_valid      = w_drain;
    assign bus.m_data       = w_drain ? r_outBuf[r_rdOut] : 8'sd0;
    assign bus.m_last       = w_drain && w_lastOut;
    assign bus.err_overflow = r_err;

endmodule

// File: tb/tb_mvprod_sched.sv
// tb_mvprod_sched -- directed bench for mvprod_sched with default parameters.
// Expected chunks and results are queued when the stimulus is driven and
// popped when the scheduler presents them.
module tb_mvprod_sched;

    localparam int IN_LEN  = 6;
    localparam int OUT_LEN = 4;
    localparam int WR      = 3;

    logic clk_in = 1'b0;
    logic rst_in;

    mvprod_sched_if #(.WORKING_REGS(WR)) bus ();

    mvprod_sched #(
        .IN_VEC_LEN   (IN_LEN),
        .OUT_VEC_LEN  (OUT_LEN),
        .WORKING_REGS (WR)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    // Free-running 100 MHz clock
    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    logic [WR*8-1:0]   chunkQ  [$];
    logic signed [7:0] resultQ [$];

    // Element 0 sits in the low byte of each packed vector
    localparam logic [IN_LEN*8-1:0] VEC_A = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [IN_LEN*8-1:0] VEC_B = {8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10};
    localparam logic [IN_LEN*8-1:0] VEC_C = {8'd60, 8'hC8, 8'd7, 8'h80, 8'hFE, 8'd127};

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive every input for one cycle, then step to just after the next rising edge
    task automatic applyStimulus(input logic sValid, input logic [7:0] sData,
                                 input logic chunkIn, input logic ptrRst,
                                 input logic chunkOut, input logic [7:0] result,
                                 input logic mReady);
        bus.s_valid          = sValid;
        bus.s_data           = sData;
        bus.mv_req_chunk_in  = chunkIn;
        bus.mv_req_ptr_rst   = ptrRst;
        bus.mv_req_chunk_out = chunkOut;
        bus.mv_result        = result;
        bus.m_ready          = mReady;
        tick();
    endtask

    function automatic logic signed [7:0] expectCapture(input logic signed [7:0] v);
`ifdef MVPROD_SCHED_RELU_EN
        return (v < 0) ? 8'sd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic loadVector(input logic [IN_LEN*8-1:0] vec);
        for (int i = 0; i < IN_LEN; i++) begin
            checkOutput("s_ready_load", bus.s_ready, 1);
            applyStimulus(1'b1, vec[i*8 +: 8], 0, 0, 0, 8'd0, 0);
        end
        checkOutput("s_ready_drop", bus.s_ready, 0);
        checkOutput("mv_start_pulse", bus.mv_start, 1);
        applyStimulus(0, 8'd0, 0, 0, 0, 8'd0, 0);
        checkOutput("mv_start_clear", bus.mv_start, 0);
    endtask

    task automatic requestChunk(input logic ptrRst, input logic [IN_LEN*8-1:0] vec, input int startIdx);
        logic [WR*8-1:0] expChunk;
        for (int k = 0; k < WR; k++) begin
            expChunk[k*8 +: 8] = vec[(startIdx + k)*8 +: 8];
        end
        chunkQ.push_back(expChunk);
        applyStimulus(0, 8'd0, 1, ptrRst, 0, 8'd0, 0);
        checkOutput("mv_chunk", bus.mv_chunk, chunkQ.pop_front());
    endtask

    task automatic capture(input logic signed [7:0] v, input bit expectOut);
        if (expectOut) resultQ.push_back(expectCapture(v));
        applyStimulus(0, 8'd0, 0, 0, 1, v, 0);
    endtask

    task automatic drainStream();
        logic signed [7:0] expData;
        int budget = 2 * OUT_LEN;
        while (resultQ.size() > 0 && budget > 0) begin
            budget--;
            expData = resultQ.pop_front();
            checkOutput("m_valid_drain", bus.m_valid, 1);
            checkOutput("m_data", bus.m_data, expData);
            checkOutput("m_last", bus.m_last, resultQ.size() == 0);
            applyStimulus(0, 8'd0, 0, 0, 0, 8'd0, 1);
        end
        checkOutput("drain_left", resultQ.size(), 0);
        checkOutput("m_valid_after", bus.m_valid, 0);
        checkOutput("s_ready_after", bus.s_ready, 1);
    endtask

    // Global time limit so a stuck run still ends with a FAIL line
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence: reset, load, chunk serving, capture, drain, protocol error, aborted run
    initial begin
        rst_in = 1'b0;
        bus.s_valid = 0; bus.s_data = 0;
        bus.mv_req_chunk_in = 0; bus.mv_req_ptr_rst = 0; bus.mv_req_chunk_out = 0;
        bus.mv_result = 0; bus.m_ready = 0;
        tick();
        tick();
        checkOutput("rst_s_ready", bus.s_ready, 0);
        checkOutput("rst_m_valid", bus.m_valid, 0);
        checkOutput("rst_mv_start", bus.mv_start, 0);
        checkOutput("rst_err", bus.err_overflow, 0);
        checkOutput("rst_m_data", bus.m_data, 0);
        checkOutput("rst_m_last", bus.m_last, 0);
        checkOutput("rst_mv_chunk", bus.mv_chunk, 0);

        rst_in = 1'b1;
        applyStimulus(0, 8'd0, 0, 0, 0, 8'd0, 0);
        checkOutput("s_ready_post_rst", bus.s_ready, 1);

        // Result request while loading: ignored but flagged
        applyStimulus(0, 8'd0, 0, 0, 1, 8'd99, 0);
        checkOutput("err_in_load", bus.err_overflow, 1);
        checkOutput("still_load", bus.s_ready, 1);
        checkOutput("no_out_in_load", bus.m_valid, 0);

        loadVector(VEC_A);
        requestChunk(0, VEC_A, 0);
        requestChunk(0, VEC_A, 3);
        requestChunk(0, VEC_A, 0);
        applyStimulus(0, 8'd0, 0, 0, 0, 8'd0, 0);
        checkOutput("chunk_hold", bus.mv_chunk, {8'd3, 8'd2, 8'd1});
        requestChunk(1, VEC_A, 0);
        requestChunk(0, VEC_A, 3);
        checkOutput("s_ready_compute", bus.s_ready, 0);
        checkOutput("m_valid_compute", bus.m_valid, 0);

        capture(8'sd5, 1);
        capture(-8'sd7, 1);
        capture(8'sd0, 1);
        capture(8'sd12, 1);
        for (int c = 0; c < 2; c++) begin
            checkOutput("stall_valid", bus.m_valid, 1);
            checkOutput("stall_data", bus.m_data, resultQ[0]);
            checkOutput("stall_last", bus.m_last, 0);
            applyStimulus(0, 8'd0, 0, 0, 0, 8'd0, 0);
        end
        drainStream();
        checkOutput("err_sticky", bus.err_overflow, 1);

        // Abort a run in COMPUTE after two captures; nothing of it may come out
        loadVector(VEC_B);
        requestChunk(0, VEC_B, 0);
        capture(-8'sd1, 0);
        capture(8'sd33, 0);
        rst_in = 1'b0;
        applyStimulus(0, 8'd0, 0, 0, 0, 8'd0, 0);
        checkOutput("abort_m_valid", bus.m_valid, 0);
        checkOutput("abort_s_ready", bus.s_ready, 0);
        checkOutput("abort_err", bus.err_overflow, 0);
        checkOutput("abort_mv_chunk", bus.mv_chunk, 0);
        checkOutput("abort_m_data", bus.m_data, 0);
        rst_in = 1'b1;
        applyStimulus(0, 8'd0, 0, 0, 0, 8'd0, 0);
        checkOutput("abort_load", bus.s_ready, 1);
        checkOutput("abort_no_out", bus.m_valid, 0);

        loadVector(VEC_C);
        requestChunk(0, VEC_C, 0);
        requestChunk(0, VEC_C, 3);
        capture(-8'sd3, 1);
        capture(8'sd100, 1);
        capture(-8'sd128, 1);
        capture(8'sd127, 1);
        drainStream();
        checkOutput("err_clean_run", bus.err_overflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
